// File: rtl/writeback_ctrl_if.sv
// Bundle between decode / MEM-WB stage and the writeback controller.
// master = pipeline side driving issue and results, slave = writeback_ctrl.
interface writeback_ctrl_if;
  logic        issue_valid;
  logic        issue_wb;
  logic [1:0]  issue_dst;
  logic [1:0]  dec_src0;
  logic [1:0]  dec_src1;
  logic        dec_use_src1;
  logic        mem_wb_valid;
  logic [1:0]  mem_wb_enc;
  logic [31:0] mem_wb_result;
  logic        rf_we;
  logic [1:0]  rf_write_enc;
  logic [31:0] rf_wdata;
  logic        stall;
  logic        fwd0_en;
  logic        fwd1_en;
  logic [3:0]  pending;
  logic [7:0]  retired;
  logic        err;

  modport master (
    output issue_valid, issue_wb, issue_dst, dec_src0, dec_src1, dec_use_src1,
           mem_wb_valid, mem_wb_enc, mem_wb_result,
    input  rf_we, rf_write_enc, rf_wdata, stall, fwd0_en, fwd1_en,
           pending, retired, err
  );

  modport slave (
    input  issue_valid, issue_wb, issue_dst, dec_src0, dec_src1, dec_use_src1,
           mem_wb_valid, mem_wb_enc, mem_wb_result,
    output rf_we, rf_write_enc, rf_wdata, stall, fwd0_en, fwd1_en,
           pending, retired, err
  );
endinterface

// File: rtl/writeback_ctrl.sv
// Register writeback controller with per-register in-flight scoreboard.
// Optional writeback-to-decode forwarding is enabled by macro WB_FORWARDING_EN.
module writeback_ctrl (
  input  logic             clk,
  input  logic             resetn,
  writeback_ctrl_if.slave  bus
);
  localparam int DATA_W = 32;

  logic [1:0]        cnt [4];
  logic              vld_p1;
  logic [1:0]        enc_p1;
  logic [DATA_W-1:0] data_p1;
  logic [7:0]        retired_q;
  logic              err_q;
  logic              hit0, hit1, blk0, blk1, full, stall_c, accept;

  // 2-bit counter step; an issue and a commit on the same register cancel out
  function automatic logic [1:0] cnt_next(input logic [1:0] cur, input logic inc,
                                          input logic dec);
    logic [1:0] nxt;
    nxt = cur;
    if (inc && !dec)
      nxt = cur + 2'd1;
    else if (dec && !inc && cur != 2'd0)
      nxt = cur - 2'd1;
    return nxt;
  endfunction

`ifdef WB_FORWARDING_EN
  // Last outstanding write is on the bus this cycle: decode can take rf_wdata
  assign hit0 = (cnt[bus.dec_src0] == 2'd1) && vld_p1 && (enc_p1 == bus.dec_src0);
  assign hit1 = (cnt[bus.dec_src1] == 2'd1) && vld_p1 && (enc_p1 == bus.dec_src1);
`else
  assign hit0 = 1'b0;
  assign hit1 = 1'b0;
`endif

  assign blk0    = (cnt[bus.dec_src0] != 2'd0) && !hit0;
  assign blk1    = (cnt[bus.dec_src1] != 2'd0) && !hit1;
  assign full    = (cnt[bus.issue_dst] == 2'd3);
  assign stall_c = bus.issue_valid &&
                   (blk0 || (bus.dec_use_src1 && blk1) || (bus.issue_wb && full));
  assign accept  = bus.issue_valid && bus.issue_wb && !stall_c;

  assign bus.stall        = stall_c;
  assign bus.fwd0_en      = hit0;
  assign bus.fwd1_en      = hit1;
  assign bus.rf_we        = vld_p1;
  assign bus.rf_write_enc = enc_p1;
  assign bus.rf_wdata     = data_p1;
  assign bus.retired      = retired_q;
  assign bus.err          = err_q;

  always_comb begin
    bus.pending = 4'b0000;
    for (int i = 0; i < 4; i++)
      bus.pending[i] = (cnt[i] != 2'd0);
  end

  // p0 -> p1: latch MEM/WB result; commit from p1 retires and drains the scoreboard
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1    <= 1'b0;
      enc_p1    <= 2'd0;
      data_p1   <= '0;
      retired_q <= 8'd0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++)
        cnt[i] <= 2'd0;
    end else begin
      vld_p1 <= bus.mem_wb_valid;
      if (bus.mem_wb_valid) begin
        enc_p1  <= bus.mem_wb_enc;
        data_p1 <= bus.mem_wb_result;
      end
      if (vld_p1) begin
        retired_q <= retired_q + 8'd1;
        if (cnt[enc_p1] == 2'd0)
          err_q <= 1'b1;
      end
      for (int i = 0; i < 4; i++)
        cnt[i] <= cnt_next(cnt[i], accept && (bus.issue_dst == 2'(i)),
                           vld_p1 && (enc_p1 == 2'(i)));
    end
  end
endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed bench for writeback_ctrl; expectations follow WB_FORWARDING_EN if defined.
module tb_writeback_ctrl;
  logic clk;
  logic resetn;
  int   vectors;
  int   miscompares;

  writeback_ctrl_if bus ();

  writeback_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_wb      = 1'b0;
    bus.issue_dst     = 2'd0;
    bus.dec_src0      = 2'd0;
    bus.dec_src1      = 2'd0;
    bus.dec_use_src1  = 1'b0;
    bus.mem_wb_valid  = 1'b0;
    bus.mem_wb_enc    = 2'd0;
    bus.mem_wb_result = 32'd0;
  endtask

  task automatic issue(input logic [1:0] dst, input logic [1:0] s0);
    bus.issue_valid = 1'b1;
    bus.issue_wb    = 1'b1;
    bus.issue_dst   = dst;
    bus.dec_src0    = s0;
  endtask

  task automatic result(input logic [1:0] enc, input logic [31:0] val);
    bus.mem_wb_valid  = 1'b1;
    bus.mem_wb_enc    = enc;
    bus.mem_wb_result = val;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    tick();
    vectors++; if (bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we got %b want 0", bus.rf_we); end
    vectors++; if (bus.rf_write_enc !== 2'd0) begin miscompares++; $display("FAIL reset_enc got %0d want 0", bus.rf_write_enc); end
    vectors++; if (bus.rf_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", bus.rf_wdata); end
    vectors++; if (bus.pending !== 4'b0000) begin miscompares++; $display("FAIL reset_pending got %b want 0000", bus.pending); end
    vectors++; if (bus.retired !== 8'd0) begin miscompares++; $display("FAIL reset_retired got %0d want 0", bus.retired); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.err); end
    vectors++; if ({bus.fwd0_en, bus.fwd1_en, bus.stall} !== 3'b000) begin miscompares++; $display("FAIL reset_fwd_stall got %b want 000", {bus.fwd0_en, bus.fwd1_en, bus.stall}); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    issue(2'd2, 2'd0);
    #1;
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL basic_issue_stall got %b want 0", bus.stall); end
    tick();
    idle();
    #1;
    vectors++; if (bus.pending !== 4'b0100) begin miscompares++; $display("FAIL basic_pending_issue got %b want 0100", bus.pending); end
    tick();
    result(2'd2, 32'h0000_00AA);
    tick();
    idle();
    #1;
    vectors++; if ({bus.rf_we, bus.rf_write_enc} !== 3'b110) begin miscompares++; $display("FAIL basic_commit got we=%b enc=%0d want we=1 enc=2", bus.rf_we, bus.rf_write_enc); end
    vectors++; if (bus.rf_wdata !== 32'h0000_00AA) begin miscompares++; $display("FAIL basic_wdata got %h want 000000aa", bus.rf_wdata); end
    vectors++; if (bus.pending !== 4'b0100) begin miscompares++; $display("FAIL basic_pending_commit got %b want 0100", bus.pending); end
    tick();
    vectors++; if ({bus.rf_we, bus.rf_write_enc} !== 3'b010) begin miscompares++; $display("FAIL basic_hold got we=%b enc=%0d want we=0 enc=2", bus.rf_we, bus.rf_write_enc); end
    vectors++; if (bus.rf_wdata !== 32'h0000_00AA) begin miscompares++; $display("FAIL basic_hold_wdata got %h want 000000aa", bus.rf_wdata); end
    vectors++; if (bus.pending !== 4'b0000) begin miscompares++; $display("FAIL basic_pending_after got %b want 0000", bus.pending); end
    vectors++; if (bus.retired !== 8'd1) begin miscompares++; $display("FAIL basic_retired got %0d want 1", bus.retired); end
  endtask

  task automatic test_raw();
    logic exp_stall, exp_fwd;
`ifdef WB_FORWARDING_EN
    exp_stall = 1'b0; exp_fwd = 1'b1;
`else
    exp_stall = 1'b1; exp_fwd = 1'b0;
`endif
    issue(2'd1, 2'd0);
    tick();
    idle();
    #1;
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL raw_novalid_stall got %b want 0", bus.stall); end
    bus.issue_valid = 1'b1;
    bus.dec_src1 = 2'd1;
    #1;
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL raw_src1_unused got %b want 0", bus.stall); end
    bus.dec_use_src1 = 1'b1;
    #1;
    vectors++; if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL raw_src1_stall got %b want 1", bus.stall); end
    bus.dec_use_src1 = 1'b0;
    bus.dec_src0 = 2'd1;
    #1;
    vectors++; if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL raw_src0_stall got %b want 1", bus.stall); end
    bus.dec_use_src1 = 1'b1;
    result(2'd1, 32'h0000_0011);
    tick();
    bus.mem_wb_valid = 1'b0;
    #1;
    vectors++; if (bus.rf_we !== 1'b1) begin miscompares++; $display("FAIL raw_commit_we got %b want 1", bus.rf_we); end
    vectors++; if (bus.stall !== exp_stall) begin miscompares++; $display("FAIL raw_commit_stall got %b want %b", bus.stall, exp_stall); end
    vectors++; if ({bus.fwd0_en, bus.fwd1_en} !== {exp_fwd, exp_fwd}) begin miscompares++; $display("FAIL raw_fwd got %b want %b", {bus.fwd0_en, bus.fwd1_en}, {exp_fwd, exp_fwd}); end
    tick();
    vectors++; if ({bus.stall, bus.fwd0_en, bus.pending} !== 6'b000000) begin miscompares++; $display("FAIL raw_after got stall=%b fwd0=%b pend=%b want 0 0 0000", bus.stall, bus.fwd0_en, bus.pending); end
    idle();
    tick();
  endtask

  task automatic test_simultaneous();
    issue(2'd3, 2'd0);
    tick();
    idle();
    result(2'd3, 32'h0000_0033);
    tick();
    bus.mem_wb_valid = 1'b0;
    issue(2'd3, 2'd0);
    #1;
    vectors++; if ({bus.rf_we, bus.stall} !== 2'b10) begin miscompares++; $display("FAIL simul_same_cycle got we=%b stall=%b want we=1 stall=0", bus.rf_we, bus.stall); end
    tick();
    idle();
    #1;
    vectors++; if (bus.pending !== 4'b1000) begin miscompares++; $display("FAIL simul_pending got %b want 1000", bus.pending); end
    result(2'd3, 32'h0000_0034);
    tick();
    idle();
    tick();
    vectors++; if ({bus.pending, bus.err} !== 5'b00000) begin miscompares++; $display("FAIL simul_drain got pend=%b err=%b want 0000 0", bus.pending, bus.err); end
    vectors++; if (bus.retired !== 8'd4) begin miscompares++; $display("FAIL simul_retired got %0d want 4", bus.retired); end
  endtask

  task automatic test_saturation();
    issue(2'd0, 2'd2);
    tick();
    #1;
    vectors++; if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL sat_cnt1_stall got %b want 0", bus.stall); end
    tick();
    tick();
    vectors++; if ({bus.stall, bus.pending} !== 5'b10001) begin miscompares++; $display("FAIL sat_full got stall=%b pend=%b want 1 0001", bus.stall, bus.pending); end
    tick();
    idle();
    result(2'd0, 32'h0000_00A0);
    tick();
    result(2'd0, 32'h0000_00A1);
    #1;
    vectors++; if ({bus.rf_we, bus.rf_wdata} !== {1'b1, 32'h0000_00A0}) begin miscompares++; $display("FAIL sat_b2b_0 got we=%b data=%h want 1 000000a0", bus.rf_we, bus.rf_wdata); end
    tick();
    result(2'd0, 32'h0000_00A2);
    #1;
    vectors++; if ({bus.rf_we, bus.rf_wdata} !== {1'b1, 32'h0000_00A1}) begin miscompares++; $display("FAIL sat_b2b_1 got we=%b data=%h want 1 000000a1", bus.rf_we, bus.rf_wdata); end
    tick();
    idle();
    #1;
    vectors++; if ({bus.rf_we, bus.rf_wdata, bus.pending} !== {1'b1, 32'h0000_00A2, 4'b0001}) begin miscompares++; $display("FAIL sat_b2b_2 got we=%b data=%h pend=%b want 1 000000a2 0001", bus.rf_we, bus.rf_wdata, bus.pending); end
    tick();
    vectors++; if ({bus.rf_we, bus.pending, bus.err} !== 6'b000000) begin miscompares++; $display("FAIL sat_drained got we=%b pend=%b err=%b want 0 0000 0", bus.rf_we, bus.pending, bus.err); end
    vectors++; if (bus.retired !== 8'd7) begin miscompares++; $display("FAIL sat_retired got %0d want 7", bus.retired); end
  endtask

  task automatic test_underflow();
    result(2'd1, 32'h0000_0055);
    tick();
    idle();
    #1;
    vectors++; if ({bus.rf_we, bus.err} !== 2'b10) begin miscompares++; $display("FAIL under_commit got we=%b err=%b want 1 0", bus.rf_we, bus.err); end
    tick();
    vectors++; if ({bus.err, bus.pending} !== 5'b10000) begin miscompares++; $display("FAIL under_err got err=%b pend=%b want 1 0000", bus.err, bus.pending); end
    vectors++; if (bus.retired !== 8'd8) begin miscompares++; $display("FAIL under_retired got %0d want 8", bus.retired); end
    tick();
    tick();
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL under_sticky got %b want 1", bus.err); end
  endtask

  task automatic test_async_reset();
    issue(2'd1, 2'd0);
    tick();
    issue(2'd2, 2'd0);
    tick();
    idle();
    result(2'd1, 32'h0000_0077);
    tick();
    idle();
    #1;
    vectors++; if ({bus.rf_we, bus.pending} !== 5'b10110) begin miscompares++; $display("FAIL arst_setup got we=%b pend=%b want 1 0110", bus.rf_we, bus.pending); end
    resetn = 1'b0;
    #1;
    vectors++; if ({bus.rf_we, bus.pending, bus.err} !== 6'b000000) begin miscompares++; $display("FAIL arst_immediate got we=%b pend=%b err=%b want 0 0000 0", bus.rf_we, bus.pending, bus.err); end
    vectors++; if ({bus.retired, bus.rf_write_enc, bus.rf_wdata} !== 42'd0) begin miscompares++; $display("FAIL arst_regs got ret=%0d enc=%0d data=%h want 0 0 0", bus.retired, bus.rf_write_enc, bus.rf_wdata); end
    tick();
    resetn = 1'b1;
    issue(2'd0, 2'd1);
    bus.dec_src1 = 2'd2;
    bus.dec_use_src1 = 1'b1;
    #1;
    vectors++; if ({bus.pending, bus.stall} !== 5'b00000) begin miscompares++; $display("FAIL arst_idle got pend=%b stall=%b want 0000 0", bus.pending, bus.stall); end
    idle();
    tick();
    vectors++; if (bus.rf_we !== 1'b0) begin miscompares++; $display("FAIL arst_no_ghost got we=%b want 0", bus.rf_we); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_raw();
    test_simultaneous();
    test_saturation();
    test_underflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
